preif_stage: RTL

- Pre-IF pipeline stage for the LoongArch 5-stage core, placed directly upstream of the IF stage.
- Owns the fetch PC and issues instruction fetches on the SRAM-like inst_sram request channel (req/addr_ok).
- Hands each accepted fetch PC to IF together with a cancel flag. IF uses the flag to discard stale data_ok responses after branch or flush redirects.
- Resolves redirects that arrive while a request is outstanding, without changing an un-accepted address.

---
 rtl/cpu_defs.sv | 25 ++
 rtl/preif_redirect_buf.sv | 36 +++
 rtl/preif_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the LoongArch 5-stage core front end.
// Holds the reset PC, inter-stage bus layouts and pre-IF state encodings.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  localparam int ID_TO_PREIF_BUS_W = 34;
  localparam int PREIF_TO_IF_PC_W  = 32;

  typedef enum logic {
    PREIF_REQ  = 1'b0,
    PREIF_HOLD = 1'b1
  } preif_state_e;

  typedef struct packed {
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
  } id_to_preif_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/preif_redirect_buf.sv
// One-entry redirect buffer for redirects that arrive while a fetch is in flight.
// A buffered flush can only be replaced by another flush, never by a branch.
module preif_redirect_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        capture,
  input  logic        clear,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        redir_is_flush
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      redir_valid    <= 1'b0;
      redir_pc       <= 32'd0;
      redir_is_flush <= 1'b0;
    end else if (clear) begin
      redir_valid    <= 1'b0;
      redir_is_flush <= 1'b0;
    end else if (capture && flush) begin
      redir_valid    <= 1'b1;
      redir_pc       <= flush_target;
      redir_is_flush <= 1'b1;
    end else if (capture && br_taken && !(redir_valid && redir_is_flush)) begin
      redir_valid    <= 1'b1;
      redir_pc       <= br_target;
      redir_is_flush <= 1'b0;
    end
  end

endmodule

// File: rtl/preif_stage.sv
// Pre-IF stage: owns the fetch PC, issues inst_sram requests and hands
// accepted PCs to IF with a cancel flag for wrong-path fetches.
module preif_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        if_allowin,
  output logic        preif_to_if_valid,
  output logic [31:0] preif_to_if_pc,
  output logic        preif_to_if_cancel,
  input  logic [cpu_defs::ID_TO_PREIF_BUS_W-1:0] id_to_preif_bus,
  input  logic        flush,
  input  logic [31:0] flush_target
);
  import cpu_defs::*;

  id_to_preif_t id_bus;
  preif_state_e state;

  logic [31:0] fetch_pc;
  logic [31:0] held_pc;
  logic [31:0] next_pc;
  logic [31:0] redir_pc;
  logic        req_sticky;
  logic        redir_valid;
  logic        redir_is_flush;

  logic is_req;
  logic req;
  logic valid;
  logic handoff;
  logic redirect;
  logic direct;
  logic capture;

  assign id_bus   = id_to_preif_bus;
  assign is_req   = (state == PREIF_REQ);
  assign req      = resetn & is_req & (req_sticky | ~id_bus.br_stall);
  assign valid    = resetn & ((req & inst_sram_addr_ok) | ~is_req);
  assign handoff  = valid & if_allowin;
  assign redirect = flush | id_bus.br_taken;
  // No request in flight: redirect lands on fetch_pc directly.
  assign direct   = is_req & ~req & redirect;
  assign capture  = redirect & ~handoff & ~direct;

  always_comb begin
    next_pc = seq_pc(is_req ? fetch_pc : held_pc);
    case (1'b1)
      flush:           next_pc = flush_target;
      id_bus.br_taken: next_pc = id_bus.br_target;
      redir_valid:     next_pc = redir_pc;
      default:         ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= PREIF_REQ;
      fetch_pc   <= RESET_PC;
      held_pc    <= RESET_PC;
      req_sticky <= 1'b0;
    end else begin
      if (req && !inst_sram_addr_ok)
        req_sticky <= 1'b1;
      else if (inst_sram_addr_ok)
        req_sticky <= 1'b0;
      unique case (state)
        PREIF_REQ: begin
          if (req && inst_sram_addr_ok && !handoff) begin
            state   <= PREIF_HOLD;
            held_pc <= fetch_pc;
          end else if (handoff || direct) begin
            fetch_pc <= next_pc;
          end
        end
        PREIF_HOLD: begin
          if (handoff) begin
            state    <= PREIF_REQ;
            fetch_pc <= next_pc;
          end
        end
        default: state <= PREIF_REQ;
      endcase
    end
  end

  preif_redirect_buf u_redir (
    .clk            (clk),
    .resetn         (resetn),
    .capture        (capture),
    .clear          (handoff | direct),
    .flush          (flush),
    .flush_target   (flush_target),
    .br_taken       (id_bus.br_taken),
    .br_target      (id_bus.br_target),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .redir_is_flush (redir_is_flush)
  );

  assign inst_sram_req      = req;
  assign inst_sram_wr       = 1'b0;
  assign inst_sram_size     = 2'b10;
  assign inst_sram_wstrb    = 4'd0;
  assign inst_sram_addr     = fetch_pc;
  assign inst_sram_wdata    = 32'd0;
  assign preif_to_if_valid  = valid;
  assign preif_to_if_pc     = is_req ? fetch_pc : held_pc;
  assign preif_to_if_cancel = valid & (redirect | redir_valid);

endmodule
